// File: rtl/fetch_pkg.sv
// Shared types for the fetch controller: FSM state encoding, queue depth
// and the layout of one queued instruction entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        BUSY  = 2'd1,   // request outstanding, result will be kept
        FLUSH = 2'd2    // request outstanding, result will be dropped
    } fetch_state_e;

    localparam int FETCH_Q_DEPTH = 2;
    localparam int FETCH_CNT_W   = 2;

    // One decode-bound entry: {instr, pc, pred} = 65 bits.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO between instruction memory and decode.
// Pure storage: push, pop, flush and an occupancy count. Entry 0 is always
// the head, so the head is a plain register with no read mux. Flush wins
// over push and pop.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [FETCH_CNT_W-1:0] count_o
);

    fetch_entry_t           ent0_q, ent0_d;
    fetch_entry_t           ent1_q, ent1_d;
    logic [FETCH_CNT_W-1:0] count_q, count_d;
    logic [FETCH_CNT_W-1:0] kept;
    logic                   pop_ok;

    // Shift on pop, then write the push into the first free slot.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        pop_ok  = pop_i && (count_q != '0);
        kept    = count_q - FETCH_CNT_W'(pop_ok);
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop_ok) begin
                ent0_d = ent1_q;
            end
            if (push_i) begin
                if (kept == '0) begin
                    ent0_d = push_data_i;
                end else begin
                    ent1_d = push_data_i;
                end
            end
            count_d = kept + FETCH_CNT_W'(push_i);
        end
    end

    // Storage and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;

    // The controller only launches when the result is guaranteed a slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !flush_i && !pop_i && (count_q == FETCH_CNT_W'(FETCH_Q_DEPTH))));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: decides when the PC register advances, issues
// registered instruction-memory requests (req/ack) and queues returned
// instructions toward decode. A redirect while a request is in flight moves
// to FLUSH so the stale return is dropped.
// Optional watchdog: define FETCH_WATCHDOG_EN to enable fetch_timeout.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int WDOG_LIMIT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        br_pred,
    input  logic        miss_pred,
    input  logic        instr_ready,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_stall,
    output logic        pc_br_pred,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_pred,
    output logic        fetch_timeout
);

    if (WDOG_LIMIT < 1) begin : g_bad_limit
        $error("WDOG_LIMIT must be at least 1");
    end

    fetch_state_e           state_q, state_d;
    logic                   req_q, req_d;
    logic [31:0]            addr_q, addr_d;
    logic                   pred_q, pred_d;
    logic                   push, pop, launch;
    logic [2:0]             occ;
    logic [FETCH_CNT_W-1:0] count;
    fetch_entry_t           head, push_data;

    // Occupancy after this edge decides whether a new result would fit.
    assign instr_valid = (count != '0) && !miss_pred;
    assign pop         = instr_valid && instr_ready;
    assign push        = (state_q == BUSY) && imem_ack && !miss_pred;
    assign occ         = 3'(count) - 3'(pop) + 3'(push);
    assign launch      = !miss_pred && (state_q != FLUSH) &&
                         ((state_q == IDLE) || imem_ack) && (occ <= 3'd1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: track whether a request is outstanding and if its data is wanted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch) state_d = BUSY;
            end
            BUSY: begin
                if (imem_ack)       state_d = launch ? BUSY : IDLE;
                else if (miss_pred) state_d = FLUSH;
            end
            FLUSH: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: PC-register control and the next request registers.
    always_comb begin
        pc_stall   = !launch;
        pc_br_pred = br_pred && launch;
        req_d      = req_q;
        addr_d     = addr_q;
        pred_d     = pred_q;
        if (launch) begin
            req_d  = 1'b1;
            addr_d = pc;
            pred_d = br_pred;
        end else if (imem_ack) begin
            req_d  = 1'b0;
        end
    end

    // Request registers hold steady until the memory acknowledges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            pred_q <= 1'b0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            pred_q <= pred_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign push_data = {imem_rdata, addr_q, pred_q};

    fetch_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (miss_pred),
        .head_o      (head),
        .count_o     (count)
    );

    assign instr      = head.instr;
    assign instr_pc   = head.pc;
    assign instr_pred = head.pred;

`ifdef FETCH_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q;

    // Count wait cycles of the outstanding request, saturating at the limit.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_q == IDLE) || imem_ack) begin
            wdog_d = '0;
        end else if (wdog_q != WDOG_W'(WDOG_LIMIT)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_q || (wdog_d == WDOG_W'(WDOG_LIMIT));
        end
    end

    assign fetch_timeout = timeout_q;
`else
    assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: models the PC register and an instruction
// memory with configurable ack latency; a scoreboard holds the entries
// decode should see, and a vector table covers the cycle-exact sequences.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        br_pred;
    logic        miss_pred;
    logic        instr_ready;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic        pc_br_pred;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_pred;
    logic        fetch_timeout;

    always #5 clk = ~clk;

    fetch_ctrl #(.WDOG_LIMIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .br_pred       (br_pred),
        .miss_pred     (miss_pred),
        .instr_ready   (instr_ready),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_stall      (pc_stall),
        .pc_br_pred    (pc_br_pred),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pred    (instr_pred),
        .fetch_timeout (fetch_timeout)
    );

`ifdef FETCH_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_stall;
        bit          e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [31:0] pc_model;
    logic [31:0] pred_pc     = 32'hFFFF_FFFF;
    logic [31:0] pred_target = 32'h0;
    int          lat         = 1;
    int          mem_cnt     = 0;
    bit          stale       = 0;
    bit          prev_wait   = 0;
    logic [31:0] prev_addr   = 32'h0;
    int          proto_err   = 0;
    int          pops        = 0;
    vec_t        vecs[13];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for this cycle, let them settle, check and update the scoreboard.
    task automatic drive(input logic miss);
        miss_pred  = miss;
        pc         = pc_model;
        br_pred    = (pc_model == pred_pc);
        imem_ack   = imem_req && (mem_cnt == lat - 1);
        imem_rdata = mem_word(imem_addr);
        #1;
        if (prev_wait && (!imem_req || imem_addr != prev_addr)) proto_err++;
        if (imem_req && !imem_ack && !pc_stall) proto_err++;
        if (instr_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stale_valid: instr_valid=1 with instr_pc %0h, expected no entry", instr_pc);
            end else begin
                check("head", 128'({instr, instr_pc, instr_pred}), 128'(sb[0]));
                if (instr_ready) begin
                    void'(sb.pop_front());
                    pops++;
                end
            end
        end
        if (miss) sb.delete();
        if (imem_ack) begin
            if (!miss && !stale)
                sb.push_back(exp_t'({mem_word(imem_addr), imem_addr, imem_addr == pred_pc}));
            stale = 0;
        end else if (imem_req && miss) begin
            stale = 1;
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
    endtask

    // Update the PC-register and memory models, then cross the clock edge.
    task automatic advance(input logic [31:0] new_pc);
        if (imem_req) mem_cnt = imem_ack ? 0 : mem_cnt + 1;
        if (miss_pred)      pc_model = new_pc;
        else if (!pc_stall) pc_model = pc_br_pred ? pred_target : pc_model + 32'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input logic miss, input logic [31:0] new_pc);
        drive(miss);
        advance(new_pc);
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset       = 1'b1;
        miss_pred   = 1'b0;
        imem_ack    = 1'b0;
        br_pred     = 1'b0;
        instr_ready = 1'b1;
        pc          = 32'h0;
        imem_rdata  = 32'h0;
        #1;
        check("reset_state",
              128'({imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pred, fetch_timeout}),
              128'(0));
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        sb.delete();
        mem_cnt   = 0;
        stale     = 0;
        prev_wait = 0;
        proto_err = 0;
        pops      = 0;
        pc_model  = start_pc;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        bit seen_a;
        bit seen_v;

        // Zero-latency ack, decode always ready: one instruction per cycle.
        vecs[0]  = '{1, 1, 0, 32'h0,  0, 0, 32'h0};
        vecs[1]  = '{0, 1, 1, 32'h0,  0, 0, 32'h0};
        vecs[2]  = '{0, 1, 1, 32'h4,  0, 1, 32'h0};
        vecs[3]  = '{0, 1, 1, 32'h8,  0, 1, 32'h4};
        vecs[4]  = '{0, 1, 1, 32'hC,  0, 1, 32'h8};
        // Decode stalled: queue fills with 0 and 4, PC frozen at 8, then released.
        vecs[5]  = '{1, 0, 0, 32'h0,  0, 0, 32'h0};
        vecs[6]  = '{0, 0, 1, 32'h0,  0, 0, 32'h0};
        vecs[7]  = '{0, 0, 1, 32'h4,  1, 1, 32'h0};
        vecs[8]  = '{0, 0, 0, 32'h4,  1, 1, 32'h0};
        vecs[9]  = '{0, 0, 0, 32'h4,  1, 1, 32'h0};
        vecs[10] = '{0, 1, 0, 32'h4,  0, 1, 32'h0};
        vecs[11] = '{0, 1, 1, 32'h8,  0, 1, 32'h4};
        vecs[12] = '{0, 1, 1, 32'hC,  0, 1, 32'h8};

        lat = 1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst) do_reset(32'h0);
            instr_ready = vecs[i].ready;
            drive(1'b0);
            check($sformatf("vec%0d", i),
                  128'({imem_req, imem_addr, pc_stall, instr_valid, instr_valid ? instr_pc : 32'h0}),
                  128'({vecs[i].e_req, vecs[i].e_addr, vecs[i].e_stall, vecs[i].e_valid, vecs[i].e_ipc}));
            advance(32'h0);
        end
        check("tbl_proto", 128'(proto_err), 128'(0));

        // Ack latency 3: one instruction every 3 cycles, stalls and stable address while waiting.
        do_reset(32'h0);
        lat = 3;
        for (int i = 0; i < 13; i++) tick(1'b0, 32'h0);
        check("t2_pops", 128'(pops), 128'(3));
        check("t2_proto", 128'(proto_err), 128'(0));

        // Redirect one cycle after the request: stale return dropped, refetch at 0x100.
        do_reset(32'h0);
        lat = 3;
        tick(1'b0, 32'h0);
        tick(1'b1, 32'h100);
        seen_a = 0;
        seen_v = 0;
        for (int i = 0; i < 20 && !seen_v; i++) begin
            drive(1'b0);
            if (!seen_a && imem_req && imem_addr != 32'h0) begin
                check("t4_redirect_addr", 128'(imem_addr), 128'(32'h100));
                seen_a = 1;
            end
            if (instr_valid) begin
                check("t4_first_pc", 128'(instr_pc), 128'(32'h100));
                seen_v = 1;
            end
            advance(32'h0);
        end
        if (!seen_v) begin
            tests++;
            fails++;
            $display("FAIL t4_timeout: no instruction after redirect within 20 cycles");
        end
        check("t4_proto", 128'(proto_err), 128'(0));

        // Redirect coincident with ack while the queue holds one entry.
        do_reset(32'h0);
        lat = 2;
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0);
        drive(1'b0);
        check("t5_queue_one", 128'({instr_valid, instr_pc}), 128'({1'b1, 32'h0}));
        advance(32'h0);
        drive(1'b1);
        check("t5_ack_with_miss", 128'(imem_ack), 128'(1));
        advance(32'h100);
        drive(1'b0);
        check("t5_valid_cleared", 128'(instr_valid), 128'(0));
        advance(32'h0);
        instr_ready = 1'b1;
        seen_a = 0;
        for (int i = 0; i < 10 && !seen_a; i++) begin
            drive(1'b0);
            if (imem_req) begin
                check("t5_redirect_addr", 128'(imem_addr), 128'(32'h100));
                seen_a = 1;
            end
            advance(32'h0);
        end
        if (!seen_a) begin
            tests++;
            fails++;
            $display("FAIL t5_timeout: no request after redirect within 10 cycles");
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0);

        // Predicted-taken branch at 0x10 with target 0x40.
        do_reset(32'h10);
        pred_pc     = 32'h10;
        pred_target = 32'h40;
        lat         = 1;
        drive(1'b0);
        check("t6_pc_br_pred", 128'({pc_br_pred, pc_stall}), 128'(2'b10));
        advance(32'h0);
        tick(1'b0, 32'h0);
        drive(1'b0);
        check("t6_next_addr", 128'(imem_addr), 128'(32'h40));
        check("t6_pred_entry", 128'({instr_valid, instr_pc, instr_pred}), 128'({1'b1, 32'h10, 1'b1}));
        advance(32'h0);
        pred_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0);

        // Withheld ack: watchdog (when built in) fires after 8 wait cycles and sticks.
        do_reset(32'h0);
        lat = 1000000;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0);
            if (i == 8) check("t7_timeout_pre", 128'(fetch_timeout), 128'(0));
            advance(32'h0);
        end
        drive(1'b0);
        check("t7_timeout_set", 128'(fetch_timeout), 128'(WD_ON));
        advance(32'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0);
        drive(1'b0);
        check("t7_timeout_sticky", 128'(fetch_timeout), 128'(WD_ON));
        advance(32'h0);
        check("t7_proto", 128'(proto_err), 128'(0));

        // Reset with a request still outstanding drops it.
        do_reset(32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch stage: decides each cycle whether the PC register advances, issues instruction-memory requests with a req/ack handshake, and buffers returned instructions in a 2-entry queue toward decode (valid/ready).
- Handles misprediction redirects, including discarding a request still in flight.
- Sits between the PC register, the branch predictor, instruction memory and decode.

Parameters:
- WDOG_LIMIT, 256, cycles without imem_ack before fetch_timeout asserts (used only with FETCH_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pc  in  32  current PC from the PC register
- br_pred  in  1  predictor says current pc is a taken branch
- miss_pred  in  1  execute redirect; also wired directly to the PC register
- instr_ready  in  1  decode accepts the head entry
- imem_ack  in  1  memory returns data for imem_addr (may arrive in the same cycle as imem_req)
- imem_rdata  in  32  instruction word
- pc_stall  out  1  stall to the PC register
- pc_br_pred  out  1  br_pred gated to the PC register
- imem_req  out  1  request, registered
- imem_addr  out  32  request address, registered
- instr_valid  out  1  head entry valid
- instr  out  32  head instruction
- instr_pc  out  32  head PC
- instr_pred  out  1  head was predicted taken
- fetch_timeout  out  1  watchdog flag (0 when feature off)

Behaviour:
- Reset values: state IDLE, queue count 0, imem_req 0, imem_addr 0, the launch-time prediction bit 0, instr/instr_pc/instr_pred 0, instr_valid 0, fetch_timeout 0.
- Reset mid-request drops the outstanding request; memory is reset together with this block.
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding, result kept.
  - FLUSH: request outstanding, result discarded.
- occ = count - pop + push. Push means imem_ack in BUSY with miss_pred = 0.
- launch = !miss_pred && state != FLUSH && (state == IDLE || imem_ack) && occ <= 1.
- On the launch edge:
  - imem_addr <= pc; imem_req <= 1; the prediction bit <= br_pred.
  - The PC register advances, so pc_stall = !launch and pc_br_pred = br_pred && launch.
  - Launch-to-request latency is 1 cycle. Zero-latency ack gives 1 instruction per cycle.
- imem_req and imem_addr stay stable until imem_ack. imem_req drops after ack unless a launch occurs in the same cycle.
- Transitions:
  - IDLE: launch -> BUSY, else IDLE.
  - BUSY:
    - ack && !miss -> push {imem_rdata, imem_addr, prediction bit}; launch ? BUSY : IDLE.
    - ack && miss -> discard; IDLE.
    - !ack && miss -> FLUSH.
    - otherwise BUSY.
  - FLUSH: ack -> discard; IDLE. No launch in FLUSH. miss_pred in FLUSH keeps FLUSH (PC is redirected again).
- Queue:
  - instr_valid = (count > 0) && !miss_pred. pop = instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed.
  - The launch rule guarantees count <= 2 and that an ack always finds space. Overflow is impossible; an assertion checks it.
- miss_pred (any state) clears the queue to count 0 at the edge. This has priority over push and pop.

Optional Feature:
- Macro FETCH_WATCHDOG_EN.
- When defined: a counter increments each cycle in BUSY or FLUSH without imem_ack, and clears on ack or in IDLE.
- When the counter reaches WDOG_LIMIT, fetch_timeout sets and stays sticky until reset. Fetch behaviour is unchanged.
- When undefined: no counter; fetch_timeout is constant 0.

Decomposition:
- fetch_pkg holds:
  - state encodings IDLE/BUSY/FLUSH;
  - FETCH_Q_DEPTH = 2;
  - the queue entry layout {instr, pc, pred} (65 bits).
- Sub-module fetch_buf: 2-entry FIFO with push, pop, flush and count. It holds no control policy.

Test Plan:
- Reset, then imem_ack tied to imem_req, instr_ready = 1 -> imem_addr 0, 4, 8 on consecutive cycles; instr_valid every cycle from cycle 2 with instr_pc 0, 4, 8.
- Ack latency 3 cycles -> pc_stall high while BUSY without ack; one instruction per 3 cycles; imem_addr stable during each wait.
- instr_ready = 0, zero-latency ack -> queue holds PCs 0 and 4; launches stop; pc frozen at 8; ready = 1 releases 0 then 4 and fetch resumes at 8.
- Latency 3, miss_pred with new_pc = 0x100 one cycle after the request -> FLUSH; stale ack discarded; next imem_addr = 0x100; first valid instr_pc = 0x100; no stale instr_valid.
- miss_pred coincident with imem_ack, queue holding 1 entry -> data and queue discarded; instr_valid = 0 next cycle; next request address 0x100.
- br_pred = 1 at launch of pc 0x10 with new_pc_pred 0x40 -> instr_pred = 1 on instr_pc 0x10; next imem_addr = 0x40. With FETCH_WATCHDOG_EN and WDOG_LIMIT = 8, a withheld ack sets fetch_timeout after 8 cycles and it stays set.
